// File: rtl/input_fifo_pkg.sv
// Shared router-port parameters: flit width, default FIFO depth and flit field offsets.
package input_fifo_pkg;

    localparam int unsigned FLIT_W      = 32;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned FIFO_ADDR_W = 2;
    localparam int unsigned PARITY_BIT  = FLIT_W - 1;

    // Flit layout: even parity bit on top of the payload.
    typedef struct packed {
        logic              parity;
        logic [FLIT_W-2:0] payload;
    } flit_t;

endpackage

// File: rtl/input_fifo_if.sv
// Upstream link between a router output stage (master) and an input FIFO (slave).
interface input_fifo_if
    import input_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FLIT_W
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/input_fifo_parity_checker.sv
// Combinational even-parity check of a flit; the top bit is the parity over the rest.
module input_fifo_parity_checker #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] flit,
    output logic                  parity_ok_c
);
    assign parity_ok_c = ((^flit[DATA_WIDTH-2:0]) == flit[DATA_WIDTH-1]);
endmodule

// File: rtl/input_fifo.sv
// Router input-port FIFO with conservative two-slot ready margin and FWFT head output.
// Optional parity checking of incoming flits under INPUT_FIFO_PARITY_CHECK_EN.
module input_fifo
    import input_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FLIT_W,
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned ADDR_W     = FIFO_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input_fifo_if.slave           up,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic [ADDR_W:0]       count,
    output logic                  overflow_err
`ifdef INPUT_FIFO_PARITY_CHECK_EN
    ,
    output logic                  parity_err
`endif
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic                  full;
    logic                  pop;
    logic                  wr_fire;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == CNT_W'(0));
    assign pop     = read_en && !empty;
    assign wr_fire = up.valid_in && (!full || pop);

    // Two free slots needed: one flit may already be in flight when ready drops.
    assign up.ready_out = !rst && (count <= CNT_W'(DEPTH - 2));
    assign data_out     = mem[rd_ptr];

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= up.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_fire, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // Full implies non-empty, so a full FIFO with read_en always pops.
            if (up.valid_in && full && !read_en) begin
                overflow_err <= 1'b1;
            end
        end
    end

`ifdef INPUT_FIFO_PARITY_CHECK_EN
    logic parity_ok_c;

    input_fifo_parity_checker #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity_checker (
        .flit        (up.data_in),
        .parity_ok_c (parity_ok_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= wr_fire && !parity_ok_c;
        end
    end
`endif

endmodule

// File: tb/tb_input_fifo.sv
// Directed self-checking bench for input_fifo (DEPTH=4, 32-bit flits).
module tb_input_fifo;
    import input_fifo_pkg::*;

    logic        clk;
    logic        rst;
    logic        read_en;
    logic [31:0] data_out;
    logic        empty;
    logic [2:0]  count;
    logic        overflow_err;
`ifdef INPUT_FIFO_PARITY_CHECK_EN
    logic        parity_err;
`endif

    int checks = 0;
    int errors = 0;

    input_fifo_if #(.DATA_WIDTH(32)) bus ();

    input_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .ADDR_W     (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .up           (bus),
        .read_en      (read_en),
        .data_out     (data_out),
        .empty        (empty),
        .count        (count),
        .overflow_err (overflow_err)
`ifdef INPUT_FIFO_PARITY_CHECK_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; bus.valid_in = 1'b0; read_en = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.valid_in = 1'b0; read_en = 1'b0; bus.data_in = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.ready_out !== 1'b0) begin
                errors++; $display("FAIL rst_ready cyc%0d got %b exp 0", i, bus.ready_out);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
        checks++;
        if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready_rel got %b exp 1", bus.ready_out); end
        checks++;
        if (overflow_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", overflow_err); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.valid_in = 1'b1; bus.data_in = 32'h1111_1111;
        step();
        bus.data_in = 32'h2222_2222;
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", count); end
        checks++;
        if (data_out !== 32'h1111_1111) begin errors++; $display("FAIL b2b_head got %h exp 11111111", data_out); end
        checks++;
        if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", bus.ready_out); end
        read_en = 1'b1;
        step();
        checks++;
        if (data_out !== 32'h2222_2222) begin errors++; $display("FAIL b2b_pop_head got %h exp 22222222", data_out); end
        checks++;
        if (count !== 3'd1) begin errors++; $display("FAIL b2b_pop_count got %0d exp 1", count); end
        step();
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL b2b_drain_empty got %b exp 1", empty); end
        // read_en on empty must be ignored
        step();
        read_en = 1'b0;
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty_pop got %0d exp 0", count); end
    endtask

    task automatic test_stream_and_full_rw();
        logic [31:0] flits [8];
        logic        prev_ready;
        int          n;
        int          drop_cnt;
        flits = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0006, 32'h8000_0001,
                  32'h0000_0009, 32'h0000_000A, 32'h0000_000C, 32'h8000_0002};
        apply_reset();
        // Upstream registers data one cycle after it sees ready.
        prev_ready = 1'b0; n = 0; drop_cnt = -1;
        for (int i = 0; i < 7; i++) begin
            bus.valid_in = prev_ready;
            bus.data_in  = flits[n];
            prev_ready   = bus.ready_out;
            step();
            if (bus.valid_in) n++;
            if (bus.ready_out == 1'b0 && drop_cnt < 0) drop_cnt = int'(count);
        end
        bus.valid_in = 1'b0;
        checks++;
        if (drop_cnt != 3) begin errors++; $display("FAIL stream_drop_at got %0d exp 3", drop_cnt); end
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL stream_count got %0d exp 4", count); end
        checks++;
        if (overflow_err !== 1'b0) begin errors++; $display("FAIL stream_ovf got %b exp 0", overflow_err); end
        checks++;
        if (data_out !== 32'h0000_0003) begin errors++; $display("FAIL stream_head got %h exp 00000003", data_out); end
        // Full with simultaneous write and pop: pointers wrap, order preserved.
        bus.valid_in = 1'b1; read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.data_in = flits[4 + i];
            step();
            checks++;
            if (count !== 3'd4) begin errors++; $display("FAIL fullrw_count%0d got %0d exp 4", i, count); end
            checks++;
            if (data_out !== flits[i + 1]) begin
                errors++; $display("FAIL fullrw_head%0d got %h exp %h", i, data_out, flits[i + 1]);
            end
        end
        bus.valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (data_out !== flits[i + 5]) begin
                errors++; $display("FAIL fullrw_drain%0d got %h exp %h", i, data_out, flits[i + 5]);
            end
        end
        step();
        read_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || overflow_err !== 1'b0) begin
            errors++; $display("FAIL fullrw_end got empty=%b ovf=%b exp 1 0", empty, overflow_err);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        bus.valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.data_in = 32'h0000_0100 + i;
            step();
        end
        bus.data_in = 32'hDEAD_BEEF;
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", count); end
        checks++;
        if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow_err); end
        read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_out !== 32'h0000_0100 + i) begin
                errors++; $display("FAIL ovf_order%0d got %h exp %h", i, data_out, 32'h0000_0100 + i);
            end
            step();
        end
        read_en = 1'b0;
        step();
        step();
        checks++;
        if (empty !== 1'b1 || overflow_err !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky got empty=%b ovf=%b exp 1 1", empty, overflow_err);
        end
        apply_reset();
        checks++;
        if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow_err); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        bus.valid_in = 1'b1;
        bus.data_in = 32'h0000_0AAA; step();
        bus.data_in = 32'h0000_0BBB; step();
        bus.valid_in = 1'b0;
        apply_reset();
        checks++;
        if (count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", count); end
        bus.valid_in = 1'b1; bus.data_in = 32'h0000_0CCC;
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (data_out !== 32'h0000_0CCC || count !== 3'd1) begin
            errors++; $display("FAIL midrst_first got %h/%0d exp 00000ccc/1", data_out, count);
        end
    endtask

`ifdef INPUT_FIFO_PARITY_CHECK_EN
    task automatic test_parity();
        apply_reset();
        bus.valid_in = 1'b1; bus.data_in = 32'h0000_0001;
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad got %b exp 1", parity_err); end
        step();
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL par_pulse got %b exp 0", parity_err); end
        checks++;
        if (data_out !== 32'h0000_0001) begin errors++; $display("FAIL par_data got %h exp 00000001", data_out); end
        bus.valid_in = 1'b1; bus.data_in = 32'h8000_0001;
        step();
        bus.valid_in = 1'b0;
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good got %b exp 0", parity_err); end
    endtask
`endif

    initial begin
        rst = 1'b1; read_en = 1'b0; bus.valid_in = 1'b0; bus.data_in = '0;
        test_reset();
        test_back_to_back();
        test_stream_and_full_rw();
        test_overflow();
        test_mid_reset();
`ifdef INPUT_FIFO_PARITY_CHECK_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
